// File: rtl/tx_packet_queue_if.sv
// Handshake bundle for tx_packet_queue: two prioritised producers in, one release port out.
// master = producer/serializer side, slave = queue side.
interface tx_packet_queue_if #(parameter int W = 40);
  logic [W-1:0] a_data;
  logic         a_valid;
  logic         a_ready;
  logic [W-1:0] b_data;
  logic         b_valid;
  logic         b_ready;
  logic [W-1:0] out_data;
  logic         out_valid;

  modport master (
    output a_data, a_valid, b_data, b_valid,
    input  a_ready, b_ready, out_data, out_valid
  );

  modport slave (
    input  a_data, a_valid, b_data, b_valid,
    output a_ready, b_ready, out_data, out_valid
  );
endinterface

// File: rtl/tx_packet_queue.sv
// Packet FIFO released one entry per tick, RELEASE_DELAY+1 cycles after the tick; a beats b, ready = !full.
// Optional saturating loss counter enabled by defining TX_QUEUE_LOSS_COUNT_EN.
module tx_packet_queue #(
  parameter int DEPTH         = 4,
  parameter int RELEASE_DELAY = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tx_packet_queue_if.slave       bus,
  input  logic                   tick,
  input  logic                   data_loss,
  output logic [$clog2(DEPTH):0] level,
  output logic                   loss_seen,
  output logic [7:0]             loss_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [5:0]    DLY      = 6'(RELEASE_DELAY);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  logic [39:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [1:0]    r_state;
  logic [5:0]    r_cnt;
  logic          r_out_vld;
  logic [39:0]   r_out_dat;
  logic          r_rdy_en;
  logic          r_loss_seen;

  logic          w_full;
  logic          w_push_a;
  logic          w_push_b;
  logic          w_push;
  logic          w_pop;
  logic          w_eval;
  logic [39:0]   w_push_dat;

  assign w_full     = (r_level == FULL_LVL);
  assign w_push_a   = bus.a_valid && bus.a_ready;
  assign w_push_b   = bus.b_valid && bus.b_ready;
  assign w_push     = w_push_a || w_push_b;
  assign w_push_dat = w_push_a ? bus.a_data : bus.b_data;
  assign w_pop      = r_out_vld;

  // Decision point: end of the delay window (or the tick itself when there is no delay).
  assign w_eval = ((r_state == S_IDLE) && tick && (DLY == 6'd0)) ||
                  ((r_state == S_DELAY) && (r_cnt == DLY));

  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wr_ptr] <= w_push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_out_vld   <= 1'b0;
      r_out_dat   <= '0;
      r_rdy_en    <= 1'b0;
      r_loss_seen <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (data_loss) r_loss_seen <= 1'b1;

      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase

      r_out_vld <= 1'b0;
      if (w_eval) begin
        if (r_level != '0) begin
          r_state   <= S_ISSUE;
          r_out_vld <= 1'b1;
          r_out_dat <= r_mem[r_rd_ptr];
        end else begin
          r_state <= S_IDLE;
        end
      end else begin
        case (r_state)
          S_IDLE:  if (tick) begin
                     r_state <= S_DELAY;
                     r_cnt   <= 6'd1;
                   end
          S_DELAY: r_cnt   <= r_cnt + 6'd1;
          S_ISSUE: r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef TX_QUEUE_LOSS_COUNT_EN
  logic [7:0] r_loss_count;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_loss_count <= 8'd0;
    end else if (data_loss && (r_loss_count != 8'hFF)) begin
      r_loss_count <= r_loss_count + 8'd1;
    end
  end
  assign loss_count = r_loss_count;
`else
  assign loss_count = 8'd0;
`endif

  assign bus.a_ready   = r_rdy_en && !w_full;
  assign bus.b_ready   = r_rdy_en && !w_full && !bus.a_valid;
  assign bus.out_data  = r_out_dat;
  assign bus.out_valid = r_out_vld;
  assign level         = r_level;
  assign loss_seen     = r_loss_seen;

endmodule

// File: tb/tb_tx_packet_queue.sv
// Directed bench for tx_packet_queue: model FIFO plus a release scoreboard of {data, cycle}.
module tb_tx_packet_queue;
  localparam int D = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       data_loss = 1'b0;
  logic [2:0] level;
  logic       loss_seen;
  logic [7:0] loss_count;

  tx_packet_queue_if bus();

  tx_packet_queue #(.DEPTH(4), .RELEASE_DELAY(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .tick       (tick),
    .data_loss  (data_loss),
    .level      (level),
    .loss_seen  (loss_seen),
    .loss_count (loss_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [39:0] d;
    int          c;
  } exp_t;

  exp_t        exp_q[$];
  logic [39:0] mq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pulse = 0;
  int          p0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every release must match the oldest outstanding expectation in data and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
      n_pulse++;
      chk("release_expected", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("release_data", 64'(bus.out_data), 64'(e.d));
        chk("release_cycle", 64'(cyc), 64'(e.c));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [39:0] d);
    chk("push_a_ready", 64'(bus.a_ready), 64'd1);
    bus.a_data  = d;
    bus.a_valid = 1'b1;
    step(1);
    bus.a_valid = 1'b0;
    mq.push_back(d);
  endtask

  task automatic do_tick();
    exp_t e;
    tick = 1'b1;
    if (mq.size() != 0) begin
      e.d = mq.pop_front();
      e.c = cyc + D + 1;
      exp_q.push_back(e);
    end
    step(1);
    tick = 1'b0;
  endtask

  initial begin
    bus.a_data  = '0;
    bus.a_valid = 1'b0;
    bus.b_data  = '0;
    bus.b_valid = 1'b0;

    // Reset
    rst_n = 1'b0;
    step(2);
    chk("rst_a_ready", 64'(bus.a_ready), 64'd0);
    chk("rst_b_ready", 64'(bus.b_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_loss_seen", 64'(loss_seen), 64'd0);
    chk("rst_loss_count", 64'(loss_count), 64'd0);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_a_ready", 64'(bus.a_ready), 64'd1);
    chk("post_rst_b_ready", 64'(bus.b_ready), 64'd1);

    // Single release, tick in cycle 10 -> out_valid in cycle 13
    push_a(40'h1234567890);
    chk("single_level_1", 64'(level), 64'd1);
    while (cyc < 10) step(1);
    do_tick();
    step(D);
    chk("single_cycle", 64'(cyc), 64'd13);
    chk("single_out_valid", 64'(bus.out_valid), 64'd1);
    chk("single_out_data", 64'(bus.out_data), 64'h1234567890);
    chk("single_level_before_pop", 64'(level), 64'd1);
    step(1);
    chk("single_out_valid_drop", 64'(bus.out_valid), 64'd0);
    chk("single_level_0", 64'(level), 64'd0);

    // Arbitration: a wins, b accepted next cycle
    bus.a_data  = 40'hAA00000001;
    bus.a_valid = 1'b1;
    bus.b_data  = 40'hBB00000002;
    bus.b_valid = 1'b1;
    #1;
    chk("arb_a_ready", 64'(bus.a_ready), 64'd1);
    chk("arb_b_ready_blocked", 64'(bus.b_ready), 64'd0);
    step(1);
    bus.a_valid = 1'b0;
    mq.push_back(40'hAA00000001);
    #1;
    chk("arb_b_ready_next", 64'(bus.b_ready), 64'd1);
    step(1);
    bus.b_valid = 1'b0;
    mq.push_back(40'hBB00000002);
    chk("arb_level_2", 64'(level), 64'd2);
    do_tick();
    step(D + 2);
    do_tick();
    step(D + 2);
    chk("arb_level_0", 64'(level), 64'd0);

    // Full: 4 pushes, 5th held until a release frees a slot
    for (int i = 0; i < 4; i++) push_a(40'h1000000000 + 40'(i));
    chk("full_level_4", 64'(level), 64'd4);
    chk("full_a_ready", 64'(bus.a_ready), 64'd0);
    chk("full_b_ready", 64'(bus.b_ready), 64'd0);
    bus.a_data  = 40'h5555555555;
    bus.a_valid = 1'b1;
    step(2);
    chk("full_held_level", 64'(level), 64'd4);
    do_tick();
    step(D);
    chk("full_ready_in_release", 64'(bus.a_ready), 64'd0);
    step(1);
    chk("full_ready_after_release", 64'(bus.a_ready), 64'd1);
    chk("full_level_3", 64'(level), 64'd3);
    step(1);
    bus.a_valid = 1'b0;
    mq.push_back(40'h5555555555);
    chk("full_held_accepted", 64'(level), 64'd4);
    repeat (4) begin
      do_tick();
      step(D + 2);
    end
    chk("full_drained", 64'(level), 64'd0);

    // Push and pop in the same cycle
    push_a(40'hC100000001);
    do_tick();
    step(D);
    chk("pp_out_valid", 64'(bus.out_valid), 64'd1);
    bus.a_data  = 40'hC200000002;
    bus.a_valid = 1'b1;
    step(1);
    bus.a_valid = 1'b0;
    mq.push_back(40'hC200000002);
    chk("pp_level_unchanged", 64'(level), 64'd1);
    do_tick();
    step(D + 2);
    chk("pp_level_0", 64'(level), 64'd0);

    // Tick with empty FIFO
    p0 = n_pulse;
    do_tick();
    step(D + 3);
    chk("empty_tick_pulses", 64'(n_pulse - p0), 64'd0);

    // Second tick during DELAY is ignored
    push_a(40'hC300000003);
    p0 = n_pulse;
    do_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(D + 3);
    chk("ignored_tick_pulses", 64'(n_pulse - p0), 64'd1);
    chk("ignored_tick_level", 64'(level), 64'd0);

    // Loss flag and counter
    chk("loss_seen_clear", 64'(loss_seen), 64'd0);
    repeat (3) begin
      data_loss = 1'b1;
      step(1);
      data_loss = 1'b0;
      step(1);
    end
    chk("loss_seen_set", 64'(loss_seen), 64'd1);
`ifdef TX_QUEUE_LOSS_COUNT_EN
    chk("loss_count", 64'(loss_count), 64'd3);
`else
    chk("loss_count", 64'(loss_count), 64'd0);
`endif

    // Reset at the end of DELAY aborts the release
    push_a(40'hC400000004);
    do_tick();
    step(1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    exp_q.delete();
    mq.delete();
    p0 = n_pulse;
    chk("abort_level", 64'(level), 64'd0);
    chk("abort_loss_seen", 64'(loss_seen), 64'd0);
    chk("abort_loss_count", 64'(loss_count), 64'd0);
    chk("abort_a_ready_low", 64'(bus.a_ready), 64'd0);
    step(D + 3);
    chk("abort_pulses", 64'(n_pulse - p0), 64'd0);
    chk("abort_a_ready_high", 64'(bus.a_ready), 64'd1);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tx_packet_queue.md
TX_PACKET_QUEUE -- requirements
Module: tx_packet_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of 2, range 2..16).
REQ-002 SHALL have parameter RELEASE_DELAY, default 2, meaning cycles from sampled tick to release (range 0..40).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have ports a_data/a_valid/a_ready  in/in/out  40/1/1  high-priority producer (keyboard).
REQ-006 SHALL have ports b_data/b_valid/b_ready  in/in/out  40/1/1  low-priority producer (mouse/aux).
REQ-007 SHALL have port tick  input  1  audio-sample-request tick, also fed to the downstream serializer.
REQ-008 SHALL have port data_loss  input  1  loss flag from the downstream serializer.
REQ-009 SHALL have ports out_data/out_valid  output  40/1  packet to the serializer's in_data/in_data_valid.
REQ-010 SHALL have port level  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 SHALL have ports loss_seen/loss_count  output  1/8  sticky loss flag and saturating loss counter.

Function
REQ-012 SHALL accept at most one push per cycle; a transfer occurs when valid and ready are both high.
REQ-013 SHALL drive a_ready = !full and b_ready = !full && !a_valid, with full taken from registered level (no same-cycle pop bypass).
REQ-014 SHALL preserve acceptance order in the FIFO, including a-then-b when both are valid on consecutive cycles.
REQ-015 SHALL implement FSM IDLE -> DELAY -> ISSUE -> IDLE, with IDLE -> DELAY on tick high.
REQ-016 SHALL stay in DELAY for RELEASE_DELAY cycles; with RELEASE_DELAY=0, DELAY lasts 0 cycles.
REQ-017 SHALL evaluate level on the DELAY-to-ISSUE transition: if nonzero, assert out_valid for exactly one cycle; if zero, assert nothing and return to IDLE.
REQ-018 SHALL assert out_valid in cycle k+RELEASE_DELAY+1 when tick is sampled high in cycle k.
REQ-019 SHALL present the FIFO head on registered out_data, valid while out_valid is high, and pop the head in that same cycle.
REQ-020 SHALL ignore tick while in DELAY or ISSUE, so at most one packet is released per tick.
REQ-021 SHALL allow a push and a pop in the same cycle: level unchanged, no corruption, correct pointer wrap at DEPTH.
REQ-022 SHALL set loss_seen on data_loss high; it stays set until reset.
REQ-023 SHALL increment loss_count once per cycle in which data_loss is high, saturating at 255.

Reset
REQ-024 SHALL, while rst_n is low at a clock edge: empty the FIFO (level=0), return the FSM to IDLE, and force out_valid=0, out_data=0, loss_seen=0, loss_count=0.
REQ-025 SHALL hold a_ready=0 and b_ready=0 during reset, and set both to 1 on the first cycle after reset.
REQ-026 SHALL, on reset asserted during DELAY or ISSUE, abort the release with no out_valid pulse and no pop.

Configuration
REQ-027 SHALL, with TX_QUEUE_LOSS_COUNT_EN defined, implement loss_count per REQ-023.
REQ-028 SHALL, without TX_QUEUE_LOSS_COUNT_EN, drive loss_count constant 0 and keep the port present; loss_seen is unaffected.

Verification
REQ-029 SHALL test reset: rst_n low 2 cycles, then high -> out_valid=0, level=0, loss_seen=0; a_ready=b_ready=1 in the next cycle.
REQ-030 SHALL test single release: push 40'h1234567890 on a, then tick in cycle 10 -> out_valid high only in cycle 13 with out_data=40'h1234567890; level goes 1 to 0.
REQ-031 SHALL test arbitration: a=40'hAA00000001 and b=40'hBB00000002 valid together -> b_ready=0; b is accepted the next cycle; two ticks release AA... then BB... in that order.
REQ-032 SHALL test full: 4 pushes -> level=4, a_ready=0, 5th push held; after the next release, a_ready=1 the following cycle and the held packet is accepted.
REQ-033 SHALL test the empty and ignored-tick paths: tick with empty FIFO -> no out_valid; with 1 entry, a second tick during DELAY -> exactly one out_valid.
REQ-034 SHALL test loss counting: data_loss high for 3 single cycles -> loss_seen=1 and loss_count=3 with TX_QUEUE_LOSS_COUNT_EN; loss_count=0 without it.
